pc_fetch_stage: RTL and testbench

//  Program-counter register and instruction-fetch stage. Consumes the 32-bit next-PC produced by the

---
 rtl/pc_fetch_stage_pkg.sv | 15 +
 rtl/fetch_watchdog.sv | 33 +++
 rtl/pc_fetch_stage.sv | 118 +++++++++++
 tb/tb_pc_fetch_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_stage_pkg.sv
// Shared fetch-stage definitions: datapath width, FSM encodings and reset defaults.
package pc_fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INST = 32'h0000_0000;
    localparam int DEF_FETCH_TIMEOUT = 255;

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch timeout watchdog: saturating wait counter and sticky error flag.
module fetch_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    output logic fetch_err
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;

    // Error is raised on the same edge that the counter reaches the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (!req || ack) begin
                count <= '0;
            end else if (count != LIMIT) begin
                count <= count + 8'd1;
            end
            if (req && !ack && (count >= LIMIT - 8'd1)) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter and instruction fetch stage: req/ack memory side,
// valid/ready hand-off to decode, redirect handling and fetch watchdog.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC      = DEF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST      = DEF_NOP_INST,
    parameter int              FETCH_TIMEOUT = DEF_FETCH_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_next,
    input  logic            redirect,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_err
);

    logic [1:0]      state;
    logic [XLEN-1:0] issue_addr;

    assign pc_plus4   = pc + 32'd4;
    assign issue_addr = redirect ? pc_next : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (redirect) pc <= pc_next;
                    if (!stall) begin
                        state     <= ST_FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= issue_addr;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        pc <= pc_next;
                        if (!redirect) begin
                            inst       <= imem_rdata;
                            inst_pc    <= imem_addr;
                            inst_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= ST_HOLD;
                        end else if (!stall) begin
                            imem_addr <= pc_next;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end else if (redirect) begin
                        pc    <= pc_next;
                        state <= ST_DROP;
                    end
                end
                // Stale request still in flight: wait for its ack, then discard.
                ST_DROP: begin
                    if (redirect) pc <= pc_next;
                    if (imem_ack) begin
                        if (!stall) begin
                            state     <= ST_FETCH;
                            imem_addr <= issue_addr;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        inst_valid <= 1'b0;
                        inst       <= NOP_INST;
                        pc         <= pc_next;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                    end
                    if (redirect || inst_ready) begin
                        if (!stall) begin
                            state     <= ST_FETCH;
                            imem_req  <= 1'b1;
                            imem_addr <= issue_addr;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    fetch_watchdog #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (imem_req),
        .ack       (imem_ack),
        .fetch_err (fetch_err)
    );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: cycle table plus hand sequences, with a memory
// responder and an instruction scoreboard.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_next;
    logic        redirect;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic [31:0] tgt;

    always #5 clk = ~clk;

    // Upstream selector: A = pc_plus4, B = branch target, sel = redirect.
    assign pc_next = redirect ? tgt : pc_plus4;

    pc_fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_next    (pc_next),
        .redirect   (redirect),
        .stall      (stall),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .fetch_err  (fetch_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAAAA_0000 | ((a >> 2) + 32'd1);
    endfunction

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   mem_lat;
    bit   mem_en;
    int   wait_cnt;
    bit   dropping;

    // Memory responder and scoreboard, evaluated mid-cycle.
    initial begin
        exp_t e;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        wait_cnt   = 0;
        dropping   = 1'b0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (!rst_n) begin
                sb.delete();
                dropping = 1'b0;
                wait_cnt = 0;
            end else begin
                if (inst_valid && redirect) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                end else if (inst_valid && inst_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_underflow: got inst_pc %h with nothing expected", inst_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_inst", inst, e.word);
                        chk("sb_inst_pc", inst_pc, e.addr);
                    end
                end
                if (imem_req) begin
                    if (mem_en && wait_cnt >= mem_lat) begin
                        imem_ack   = 1'b1;
                        imem_rdata = mem_word(imem_addr);
                        wait_cnt   = 0;
                        if (dropping) begin
                            dropping = 1'b0;
                        end else if (!redirect) begin
                            e.word = mem_word(imem_addr);
                            e.addr = imem_addr;
                            sb.push_back(e);
                        end
                    end else begin
                        wait_cnt++;
                        if (redirect) dropping = 1'b1;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    typedef struct {
        logic        stall;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] inst;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic q,
                                input logic [31:0] a, input logic v,
                                input logic [31:0] p, input logic [31:0] ip,
                                input logic [31:0] in);
        vec_t x;
        x.stall = s; x.ready = r; x.req = q; x.addr = a;
        x.valid = v; x.pc = p; x.ipc = ip; x.inst = in;
        return x;
    endfunction

    vec_t vt[16];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit done;
        vt[0]  = mk(0, 1, 1, 32'h0, 0, 32'h0,  32'h0, 32'h0);
        vt[1]  = mk(0, 1, 0, 32'h0, 1, 32'h4,  32'h0, 32'hAAAA_0001);
        vt[2]  = mk(0, 1, 1, 32'h4, 0, 32'h4,  32'h0, 32'hAAAA_0001);
        vt[3]  = mk(0, 1, 0, 32'h4, 1, 32'h8,  32'h4, 32'hAAAA_0002);
        vt[4]  = mk(0, 1, 1, 32'h8, 0, 32'h8,  32'h4, 32'hAAAA_0002);
        vt[5]  = mk(0, 0, 0, 32'h8, 1, 32'hC,  32'h8, 32'hAAAA_0003);
        vt[6]  = mk(0, 0, 0, 32'h8, 1, 32'hC,  32'h8, 32'hAAAA_0003);
        vt[7]  = mk(0, 0, 0, 32'h8, 1, 32'hC,  32'h8, 32'hAAAA_0003);
        vt[8]  = mk(0, 0, 0, 32'h8, 1, 32'hC,  32'h8, 32'hAAAA_0003);
        vt[9]  = mk(0, 0, 0, 32'h8, 1, 32'hC,  32'h8, 32'hAAAA_0003);
        vt[10] = mk(0, 1, 0, 32'h8, 1, 32'hC,  32'h8, 32'hAAAA_0003);
        vt[11] = mk(0, 1, 1, 32'hC, 0, 32'hC,  32'h8, 32'hAAAA_0003);
        vt[12] = mk(1, 1, 0, 32'hC, 1, 32'h10, 32'hC, 32'hAAAA_0004);
        vt[13] = mk(1, 1, 0, 32'hC, 0, 32'h10, 32'hC, 32'hAAAA_0004);
        vt[14] = mk(1, 1, 0, 32'hC, 0, 32'h10, 32'hC, 32'hAAAA_0004);
        vt[15] = mk(0, 1, 0, 32'hC, 0, 32'h10, 32'hC, 32'hAAAA_0004);

        rst_n      = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        tgt        = '0;
        inst_ready = 1'b1;
        mem_en     = 1'b1;
        mem_lat    = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chkb("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chkb("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chkb("rst_err", fetch_err, 1'b0);
        rst_n = 1'b1;

        // Sequential fetch, backpressure and stall.
        for (int i = 0; i < 16; i++) begin
            next();
            stall      = vt[i].stall;
            inst_ready = vt[i].ready;
            chkb("tbl_req", imem_req, vt[i].req);
            chk("tbl_addr", imem_addr, vt[i].addr);
            chkb("tbl_valid", inst_valid, vt[i].valid);
            chk("tbl_pc", pc, vt[i].pc);
            chk("tbl_inst_pc", inst_pc, vt[i].ipc);
            chk("tbl_inst", inst, vt[i].inst);
        end

        // Redirect while a request is outstanding.
        next();
        mem_lat  = 3;
        redirect = 1'b1;
        tgt      = 32'h100;
        chkb("t4_req", imem_req, 1'b1);
        chk("t4_addr", imem_addr, 32'h10);
        done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next();
            redirect = 1'b0;
            if (imem_req && imem_addr == 32'h100) begin
                done = 1'b1;
                break;
            end
            chk("t4_addr_hold", imem_addr, 32'h10);
            chkb("t4_valid", inst_valid, 1'b0);
            chk("t4_pc", pc, 32'h100);
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL t4_reissue: got addr %h expected 00000100 within 10 cycles", imem_addr);
        end
        chkb("t4_valid_drop", inst_valid, 1'b0);
        mem_lat = 0;
        next();
        chkb("t4_new_valid", inst_valid, 1'b1);
        chk("t4_new_inst_pc", inst_pc, 32'h100);
        chk("t4_new_pc", pc, 32'h104);

        // Redirect with same-cycle ack, then redirect in HOLD, then wrap.
        next();
        chkb("t5_req", imem_req, 1'b1);
        chk("t5_addr", imem_addr, 32'h104);
        redirect = 1'b1;
        tgt      = 32'h200;
        next();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        chkb("t5_req2", imem_req, 1'b1);
        chk("t5_addr2", imem_addr, 32'h200);
        chkb("t5_valid2", inst_valid, 1'b0);
        chk("t5_pc2", pc, 32'h200);
        next();
        chkb("t5_valid3", inst_valid, 1'b1);
        chk("t5_inst_pc3", inst_pc, 32'h200);
        chk("t5_inst3", inst, mem_word(32'h200));
        redirect   = 1'b1;
        tgt        = 32'hFFFF_FFFC;
        inst_ready = 1'b1;
        next();
        redirect = 1'b0;
        chkb("t5_valid4", inst_valid, 1'b0);
        chk("t5_nop", inst, 32'h0);
        chk("t5_addr4", imem_addr, 32'hFFFF_FFFC);
        chk("t5_pc4", pc, 32'hFFFF_FFFC);
        chk("t5_wrap", pc_plus4, 32'h0);
        next();
        chk("t5_pc_wrapped", pc, 32'h0);
        chkb("t5_valid5", inst_valid, 1'b1);
        chk("t5_inst_pc5", inst_pc, 32'hFFFF_FFFC);
        mem_lat = 100;

        // Reset asserted mid-fetch.
        next();
        chkb("t1_req_before", imem_req, 1'b1);
        chk("t1_inst_before", inst, mem_word(32'hFFFF_FFFC));
        #2;
        rst_n = 1'b0;
        #1;
        chkb("t1_req", imem_req, 1'b0);
        chkb("t1_valid", inst_valid, 1'b0);
        chk("t1_inst", inst, 32'h0);
        chk("t1_inst_pc", inst_pc, 32'h0);
        chk("t1_pc", pc, 32'h0);

        // Fetch timeout.
        mem_en  = 1'b0;
        mem_lat = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            next();
            if (k == 1) begin
                chkb("t1_release_req", imem_req, 1'b1);
                chk("t1_release_addr", imem_addr, 32'h0);
            end
            if (k == 255) chkb("t6_err_early", fetch_err, 1'b0);
            if (k == 256) begin
                chkb("t6_err_set", fetch_err, 1'b1);
                chkb("t6_req_held", imem_req, 1'b1);
            end
        end
        mem_en = 1'b1;
        next();
        chkb("t6_late_valid", inst_valid, 1'b1);
        chk("t6_late_inst_pc", inst_pc, 32'h0);
        chkb("t6_err_sticky", fetch_err, 1'b1);
        repeat (3) next();
        chkb("t6_err_sticky2", fetch_err, 1'b1);
        rst_n = 1'b0;
        #1;
        chkb("t6_err_cleared", fetch_err, 1'b0);
        chkb("t6_req_cleared", imem_req, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        next();
        chkb("t6_restart_req", imem_req, 1'b1);
        chk("t6_restart_addr", imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
